reg_access_sequencer: RTL and testbench

REG_ACCESS_SEQUENCER -- requirements
Module: reg_access_sequencer

---
 rtl/reg_access_sequencer_if.sv | 43 ++++
 rtl/reg_access_sequencer.sv | 149 ++++++++++++++
 tb/tb_reg_access_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_sequencer_if.sv
// Bundle of the command/response handshake and the register_bank port
// seen by reg_access_sequencer.
//
//   cmd_valid / cmd_ready      command handshake (accept when both are 1)
//   cmd_op, cmd_src, cmd_dst,  command fields: 00 READ, 01 WRITE, 10 MOVE,
//   cmd_data                   11 SWAP; source/destination selectors, data
//   rsp_valid / rsp_data       one-cycle completion pulse and its data
//   rb_selector, rb_in_data,   drive side of the register_bank
//   rb_write_en, rb_read_en
//   rb_out_data                register_bank read data (one cycle latency)
//
// slave  : the sequencer side.
// master : the command issuer / register_bank side.
interface reg_access_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [SEL_W-1:0]  cmd_src;
    logic [SEL_W-1:0]  cmd_dst;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [SEL_W-1:0]  rb_selector;
    logic [DATA_W-1:0] rb_in_data;
    logic              rb_write_en;
    logic              rb_read_en;
    logic [DATA_W-1:0] rb_out_data;

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data, rb_out_data,
        output cmd_ready, rsp_valid, rsp_data,
               rb_selector, rb_in_data, rb_write_en, rb_read_en
    );

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data, rb_out_data,
        input  cmd_ready, rsp_valid, rsp_data,
               rb_selector, rb_in_data, rb_write_en, rb_read_en
    );
endinterface

// File: rtl/reg_access_sequencer.sv
// Sequences READ / WRITE / MOVE / SWAP commands onto a single-port
// register_bank. One command in flight at a time; a one-cycle rsp_valid
// pulse marks completion.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    reg_access_sequencer_if.slave (command, response, bank port)
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | cmd_ready=1, waiting for a command
// RD_A   | read_en on src
// CAP_A  | bank data for src captured into tmp_a on exit
// RD_B   | read_en on dst (SWAP only)
// CAP_B  | bank data for dst captured into tmp_b on exit (SWAP only)
// WR_A   | write dst with tmp_a (cmd_data for WRITE)
// WR_B   | write src with tmp_b (SWAP only)
// DONE   | rsp_valid pulse, always returns to IDLE
module reg_access_sequencer #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_access_sequencer_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_A  = 3'd1;
    localparam logic [2:0] CAP_A = 3'd2;
    localparam logic [2:0] RD_B  = 3'd3;
    localparam logic [2:0] CAP_B = 3'd4;
    localparam logic [2:0] WR_A  = 3'd5;
    localparam logic [2:0] WR_B  = 3'd6;
    localparam logic [2:0] DONE  = 3'd7;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    logic [2:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [SEL_W-1:0]  src_q, src_d;
    logic [SEL_W-1:0]  dst_q, dst_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] tmp_a_q, tmp_a_d;
    logic [DATA_W-1:0] tmp_b_q, tmp_b_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            tmp_a_q <= '0;
            tmp_b_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            tmp_a_q <= tmp_a_d;
            tmp_b_q <= tmp_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        tmp_a_d = tmp_a_q;
        tmp_b_d = tmp_b_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    src_d   = bus.cmd_src;
                    dst_d   = bus.cmd_dst;
                    data_d  = bus.cmd_data;
                    state_d = (bus.cmd_op == OP_WRITE) ? WR_A : RD_A;
                end
            end
            RD_A: state_d = CAP_A;
            CAP_A: begin
                tmp_a_d = bus.rb_out_data;
                case (op_q)
                    OP_MOVE: state_d = WR_A;
                    OP_SWAP: state_d = RD_B;
                    default: state_d = DONE;
                endcase
            end
            RD_B: state_d = CAP_B;
            CAP_B: begin
                tmp_b_d = bus.rb_out_data;
                state_d = WR_A;
            end
            WR_A: state_d = (op_q == OP_SWAP) ? WR_B : DONE;
            WR_B: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs. cmd_ready is gated by rst_n so it reads 0 while reset
    // is held, even though the state register already sits in IDLE.
    always_comb begin
        bus.cmd_ready   = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_data    = '0;
        bus.rb_selector = '0;
        bus.rb_in_data  = '0;
        bus.rb_write_en = 1'b0;
        bus.rb_read_en  = 1'b0;
        case (state_q)
            IDLE: bus.cmd_ready = rst_n;
            RD_A: begin
                bus.rb_read_en  = 1'b1;
                bus.rb_selector = src_q;
            end
            RD_B: begin
                bus.rb_read_en  = 1'b1;
                bus.rb_selector = dst_q;
            end
            WR_A: begin
                bus.rb_write_en = 1'b1;
                bus.rb_selector = dst_q;
                bus.rb_in_data  = (op_q == OP_WRITE) ? data_q : tmp_a_q;
            end
            WR_B: begin
                bus.rb_write_en = 1'b1;
                bus.rb_selector = src_q;
                bus.rb_in_data  = tmp_b_q;
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                // READ/MOVE/SWAP all report the value originally read from src.
                bus.rsp_data  = (op_q == OP_WRITE) ? data_q : tmp_a_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_access_sequencer.sv
module tb_reg_access_sequencer;
    localparam int DW = 8;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_access_sequencer_if #(.DATA_W(DW), .SEL_W(SW)) bus ();
    reg_access_sequencer #(.DATA_W(DW), .SEL_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // register_bank model: not reset by rst_n, one-cycle read latency
    logic [7:0] bank [8] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.rb_write_en) bank[bus.rb_selector] <= bus.rb_in_data;
        if (bus.rb_read_en)  bus.rb_out_data <= bank[bus.rb_selector];
    end

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] data; int unsigned lat; int unsigned acc; } rsp_t;
    typedef struct { logic [2:0] sel; logic [7:0] data; } wr_t;
    rsp_t rsp_q [$];
    wr_t  wr_q  [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned lat_of(input logic [1:0] op);
        case (op)
            2'b00:   return 3;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 7;
        endcase
    endfunction

    // monitor
    rsp_t er;
    wr_t  ew;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid data %0h expected no response", bus.rsp_data);
                end else begin
                    er = rsp_q.pop_front();
                    check("rsp_data", int'(bus.rsp_data), int'(er.data));
                    check("rsp_latency", int'(cyc - er.acc), int'(er.lat));
                end
            end
            if (bus.rb_write_en) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got write sel %0d data %0h expected no write", bus.rb_selector, bus.rb_in_data);
                end else begin
                    ew = wr_q.pop_front();
                    check("wr_sel", int'(bus.rb_selector), int'(ew.sel));
                    check("wr_data", int'(bus.rb_in_data), int'(ew.data));
                end
            end
            if (bus.rb_read_en || bus.rb_write_en)
                check("rd_wr_exclusive", int'(bus.rb_read_en & bus.rb_write_en), 0);
            if (bus.cmd_ready)
                check("ready_only_idle", int'(bus.rb_read_en | bus.rb_write_en | bus.rsp_valid), 0);
        end
    end

    task automatic expect_wr(input logic [2:0] sel, input logic [7:0] data);
        wr_t w;
        w.sel = sel; w.data = data;
        wr_q.push_back(w);
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                         input logic [7:0] data, input logic [7:0] exp,
                         input bit expect_rsp, input bit hold);
        int budget;
        rsp_t e;
        budget = 0;
        @(negedge clk);
        while (!bus.cmd_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.cmd_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got cmd_ready 0 expected 1");
            return;
        end
        bus.cmd_op = op; bus.cmd_src = src; bus.cmd_dst = dst; bus.cmd_data = data;
        bus.cmd_valid = 1'b1;
        if (expect_rsp) begin
            e.data = exp; e.lat = lat_of(op); e.acc = cyc;
            rsp_q.push_back(e);
        end
        @(posedge clk);
        if (!hold) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("drain_rsp_pending", rsp_q.size(), 0);
        check("drain_wr_pending", wr_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cmd_ready"}, int'(bus.cmd_ready), 0);
        check({tag, "_read_en"}, int'(bus.rb_read_en), 0);
        check({tag, "_write_en"}, int'(bus.rb_write_en), 0);
        check({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        check({tag, "_selector"}, int'(bus.rb_selector), 0);
        check({tag, "_in_data"}, int'(bus.rb_in_data), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1);
    end

    initial begin
        rsp_t e;
        int budget;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00; bus.cmd_src = '0; bus.cmd_dst = '0; bus.cmd_data = '0;

        repeat (2) @(negedge clk);
        check_outputs_zero("reset");

        // release reset and present WRITE r4=AA for the very first edge
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", int'(bus.cmd_ready), 1);
        bus.cmd_op = 2'b01; bus.cmd_src = 3'd0; bus.cmd_dst = 3'd4; bus.cmd_data = 8'hAA;
        bus.cmd_valid = 1'b1;
        expect_wr(3'd4, 8'hAA);
        e.data = 8'hAA; e.lat = 2; e.acc = cyc;
        rsp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        issue(2'b00, 3'd4, 3'd0, 8'h00, 8'hAA, 1, 0);            // READ r4
        drain();

        // WRITE r0, MOVE r0->r7, READ r7
        expect_wr(3'd0, 8'h0F);
        issue(2'b01, 3'd0, 3'd0, 8'h0F, 8'h0F, 1, 0);
        expect_wr(3'd7, 8'h0F);
        issue(2'b10, 3'd0, 3'd7, 8'h00, 8'h0F, 1, 0);
        issue(2'b00, 3'd7, 3'd0, 8'h00, 8'h0F, 1, 0);
        drain();

        // SWAP r1/r2
        expect_wr(3'd1, 8'h11);
        issue(2'b01, 3'd0, 3'd1, 8'h11, 8'h11, 1, 0);
        expect_wr(3'd2, 8'h22);
        issue(2'b01, 3'd0, 3'd2, 8'h22, 8'h22, 1, 0);
        expect_wr(3'd2, 8'h11);
        expect_wr(3'd1, 8'h22);
        issue(2'b11, 3'd1, 3'd2, 8'h00, 8'h11, 1, 0);
        issue(2'b00, 3'd1, 3'd0, 8'h00, 8'h22, 1, 0);
        issue(2'b00, 3'd2, 3'd0, 8'h00, 8'h11, 1, 0);
        drain();

        // SWAP with src==dst
        expect_wr(3'd3, 8'h5C);
        issue(2'b01, 3'd0, 3'd3, 8'h5C, 8'h5C, 1, 0);
        expect_wr(3'd3, 8'h5C);
        expect_wr(3'd3, 8'h5C);
        issue(2'b11, 3'd3, 3'd3, 8'h00, 8'h5C, 1, 0);
        issue(2'b00, 3'd3, 3'd0, 8'h00, 8'h5C, 1, 0);
        drain();

        // cmd_valid held high across back-to-back commands
        expect_wr(3'd5, 8'h3A);
        issue(2'b01, 3'd0, 3'd5, 8'h3A, 8'h3A, 1, 1);
        issue(2'b00, 3'd5, 3'd0, 8'h00, 8'h3A, 1, 1);
        expect_wr(3'd6, 8'h3A);
        issue(2'b10, 3'd5, 3'd6, 8'h00, 8'h3A, 1, 1);
        issue(2'b00, 3'd6, 3'd0, 8'h00, 8'h3A, 1, 0);
        drain();

        // reset during SWAP while in RD_B (r1=22, r2=11)
        issue(2'b11, 3'd1, 3'd2, 8'h00, 8'h00, 0, 0);
        budget = 0;
        while (!(bus.rb_read_en && bus.rb_selector == 3'd2) && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check("reach_rd_b", int'(bus.rb_read_en && bus.rb_selector == 3'd2), 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(2'b00, 3'd1, 3'd0, 8'h00, 8'h22, 1, 0);
        issue(2'b00, 3'd2, 3'd0, 8'h00, 8'h11, 1, 0);
        drain();

        check("bank_r1", int'(bank[1]), 8'h22);
        check("bank_r2", int'(bank[2]), 8'h11);
        check("bank_r3", int'(bank[3]), 8'h5C);
        check("bank_r4", int'(bank[4]), 8'hAA);
        check("bank_r6", int'(bank[6]), 8'h3A);
        check("bank_r7", int'(bank[7]), 8'h0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
